crg_switch_ctrl: RTL and testbench

//  Control-side initiator for the clock/reset generator (CRG) sub-top.

---
 rtl/crg_switch_ctrl_if.sv | 11 +
 rtl/crg_switch_ctrl.sv | 120 ++++++++++++
 tb/tb_crg_switch_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/crg_switch_ctrl_if.sv
// Request handshake between the CRG control master and crg_switch_ctrl.
interface crg_switch_ctrl_if #(
  parameter int unsigned SEL_W = 2
);
  logic             req_valid_i;
  logic [SEL_W-1:0] req_sel_i;
  logic             req_ready_o;

  modport master (output req_valid_i, output req_sel_i, input req_ready_o);
  modport slave  (input req_valid_i, input req_sel_i, output req_ready_o);
endinterface

// File: rtl/crg_switch_ctrl.sv
// CRG PLL-source switch sequencer: reset request, gate, switch select,
// settle, ungate, release. Runs in the always-on ref_clk domain.
module crg_switch_ctrl #(
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned RESET_SEL   = 0,
  parameter int unsigned RST_HOLD    = 8,
  parameter int unsigned GATE_WAIT   = 4,
  parameter int unsigned SETTLE_WAIT = 16
) (
  input  logic                ref_clk_i,
  input  logic                rst_i,
  crg_switch_ctrl_if.slave    req,
  output logic [SEL_W-1:0]    sel_o,
  output logic                en_o,
  output logic                arst_req_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned MAX_A    = (RST_HOLD > GATE_WAIT) ? RST_HOLD : GATE_WAIT;
  localparam int unsigned MAX_WAIT = (MAX_A > SETTLE_WAIT) ? MAX_A : SETTLE_WAIT;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_WAIT - 1);
  localparam logic [SEL_W-1:0] SEL_RST   = SEL_W'(RESET_SEL);

  typedef enum logic [2:0] {
    IDLE,
    RST_ASSERT,
    GATE,
    SWITCH,
    UNGATE,
    RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] target;

  // Handshake status is a pure decode of the registered state.
  assign req.req_ready_o = (state == IDLE);
  assign busy_o          = (state != IDLE);

  // Sequencer: each timed state loads cnt with its length-1 on entry and
  // leaves when cnt reaches 0; outputs change only on state entry.
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      target     <= SEL_RST;
      sel_o      <= SEL_RST;
      en_o       <= 1'b1;
      arst_req_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid_i) begin
            target <= req.req_sel_i;
            if (req.req_sel_i == sel_o) begin
              // Nothing to switch: complete immediately without touching en/arst.
              state  <= RELEASE;
              done_o <= 1'b1;
            end else begin
              state      <= RST_ASSERT;
              arst_req_o <= 1'b1;
              cnt        <= RST_LD;
            end
          end
        end
        RST_ASSERT: begin
          if (cnt == '0) begin
            state <= GATE;
            en_o  <= 1'b0;
            cnt   <= GATE_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GATE: begin
          if (cnt == '0) begin
            state <= SWITCH;
            sel_o <= target;
            cnt   <= SETTLE_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SWITCH: begin
          if (cnt == '0) begin
            state <= UNGATE;
            en_o  <= 1'b1;
            cnt   <= GATE_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        UNGATE: begin
          if (cnt == '0) begin
            state      <= RELEASE;
            arst_req_o <= 1'b0;
            done_o     <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crg_switch_ctrl.sv
// Self-checking bench for crg_switch_ctrl: default-parameter DUT plus a
// minimum-timing DUT (all waits = 1).
module tb_crg_switch_ctrl;

  logic       ref_clk;
  logic       rst;
  logic [1:0] sel0, sel1;
  logic       en0, en1, arst0, arst1, busy0, busy1, done0, done1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int viol = 0;

  crg_switch_ctrl_if #(.SEL_W(2)) req0 ();
  crg_switch_ctrl_if #(.SEL_W(2)) req1 ();

  crg_switch_ctrl #(
    .SEL_W(2), .RESET_SEL(0), .RST_HOLD(8), .GATE_WAIT(4), .SETTLE_WAIT(16)
  ) dut0 (
    .ref_clk_i(ref_clk), .rst_i(rst), .req(req0),
    .sel_o(sel0), .en_o(en0), .arst_req_o(arst0), .busy_o(busy0), .done_o(done0)
  );

  crg_switch_ctrl #(
    .SEL_W(2), .RESET_SEL(0), .RST_HOLD(1), .GATE_WAIT(1), .SETTLE_WAIT(1)
  ) dut1 (
    .ref_clk_i(ref_clk), .rst_i(rst), .req(req1),
    .sel_o(sel1), .en_o(en1), .arst_req_o(arst1), .busy_o(busy1), .done_o(done1)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  // Output invariants, both DUTs, every cycle outside reset recovery.
  logic       inv_started = 1'b0;
  logic       prev_rst = 1'b1;
  logic [1:0] psel0, psel1;
  logic       pen0, pen1;
  always @(negedge ref_clk) begin
    if (inv_started) begin
      if (!en0 && !arst0) viol++;
      if (!en1 && !arst1) viol++;
      if (!prev_rst && (sel0 != psel0) && (pen0 || en0)) viol++;
      if (!prev_rst && (sel1 != psel1) && (pen1 || en1)) viol++;
    end
    inv_started = 1'b1;
    prev_rst = rst;
    psel0 = sel0; psel1 = sel1;
    pen0 = en0;   pen1 = en1;
  end

  // Packed observation: {sel[1:0], en, arst, ready, busy, done}
  function automatic logic [6:0] obs(input int d);
    if (d == 0) return {sel0, en0, arst0, req0.req_ready_o, busy0, done0};
    else        return {sel1, en1, arst1, req1.req_ready_o, busy1, done1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic set_req(input int d, input logic v, input logic [1:0] s);
    if (d == 0) begin req0.req_valid_i = v; req0.req_sel_i = s; end
    else        begin req1.req_valid_i = v; req1.req_sel_i = s; end
  endtask

  // Caller has valid raised in the current cycle (cycle 0) with ready=1.
  // Checks every cycle through the return to IDLE.
  task automatic run_switch(input int d, input int rh, input int gw, input int sw,
                            input logic [1:0] old_sel, input logic [1:0] new_sel,
                            input string tag);
    int last;
    logic [6:0] e;
    logic exp_en, exp_arst, exp_done, exp_busy;
    logic [1:0] exp_sel;
    last = 1 + rh + 2*gw + sw;
    step();
    set_req(d, 1'b0, new_sel);
    for (int c = 1; c <= last + 1; c++) begin
      exp_arst = (c <= last - 1);
      exp_en   = !((c >= 1 + rh) && (c <= rh + gw + sw));
      exp_sel  = (c >= 1 + rh + gw) ? new_sel : old_sel;
      exp_done = (c == last);
      exp_busy = (c <= last);
      e = {exp_sel, exp_en, exp_arst, !exp_busy, exp_busy, exp_done};
      chk($sformatf("%s@cyc%0d", tag, c), 32'(obs(d)), 32'(e));
      if (c <= last) step();
    end
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic       valid;
    logic [1:0] sel_in;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[5];

  int acc;
  int dn;

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 2'd0);
    set_req(1, 1'b0, 2'd0);

    vecs[0] = '{"reset_1",        1'b1, 1'b0, 2'd0, 7'b00_1_0_1_0_0};
    vecs[1] = '{"reset_vs_valid", 1'b1, 1'b1, 2'd3, 7'b00_1_0_1_0_0};
    vecs[2] = '{"same_sel_acc",   1'b0, 1'b1, 2'd0, 7'b00_1_0_0_1_1};
    vecs[3] = '{"same_sel_idle",  1'b0, 1'b0, 2'd0, 7'b00_1_0_1_0_0};
    vecs[4] = '{"idle_hold",      1'b0, 1'b0, 2'd0, 7'b00_1_0_1_0_0};

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      set_req(0, vecs[i].valid, vecs[i].sel_in);
      step();
      chk(vecs[i].name, 32'(obs(0)), 32'(vecs[i].exp));
    end
    chk("reset_dut1", 32'(obs(1)), 32'(7'b00_1_0_1_0_0));

    // Full switch 0 -> 2 at default timing
    set_req(0, 1'b1, 2'd2);
    run_switch(0, 8, 4, 16, 2'd0, 2'd2, "sw02");

    // Request held while busy: first 2->0, then sel=3 waits for ready
    set_req(0, 1'b1, 2'd0);
    step();
    set_req(0, 1'b1, 2'd3);
    acc = 0;
    for (int c = 1; c <= 33; c++) begin
      if (req0.req_ready_o) acc++;
      if (c == 33) begin
        chk("busy_first_done", 32'(done0), 32'd1);
        chk("busy_first_sel", 32'(sel0), 32'd0);
      end
      step();
    end
    chk("busy_ready_low_cycles", 32'(acc), 32'd0);
    chk("busy_ready_return", 32'(req0.req_ready_o), 32'd1);
    run_switch(0, 8, 4, 16, 2'd0, 2'd3, "sw03");

    // Reset in the middle of SWITCH (cycle 20)
    set_req(0, 1'b1, 2'd1);
    step();
    set_req(0, 1'b0, 2'd1);
    repeat (19) step();
    chk("midsw_state", 32'({sel0, en0, arst0}), 32'({2'd1, 1'b0, 1'b1}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midsw_reset", 32'(obs(0)), 32'(7'b00_1_0_1_0_0));
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (done0) dn++;
      step();
    end
    chk("midsw_no_done", 32'(dn), 32'd0);

    // Minimum timing DUT: 0 -> 1, done at cycle 5
    set_req(1, 1'b1, 2'd1);
    run_switch(1, 1, 1, 1, 2'd0, 2'd1, "sweep");

    step();
    chk("invariants", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
